// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-outstanding memory port; read gnt->rvalid MEM_LAT+1, store ack 2.
// Requests wait (gnt low) until the FSM is back in IDLE; there is no queueing.
module mem_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write_en,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        is_d;
  } req_t;

  state_t      state, state_nxt;
  req_t        cur;
  logic [3:0]  cnt;
  logic [2:0]  starve_cnt;
  logic [31:0] if_rdata_q, d_rdata_q;
  logic        misaligned, pick_i, pick_d;
  logic [31:0] rsp_data;

  assign misaligned = (cur.addr[1:0] != 2'b00);
  // Data has priority unless the fetch side has been passed over STARVE_MAX times.
  assign pick_i     = if_req && (!d_req || (starve_cnt == 3'(STARVE_MAX)));
  assign pick_d     = d_req && !pick_i;
  assign rsp_data   = (cur.we || misaligned) ? 32'h0 : mem_rdata;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;
    mem_rd_en    = 1'b0;
    mem_write_en = 1'b0;
    mem_addr     = 32'h0;
    mem_wdata    = 32'h0;
    if_rvalid    = 1'b0;
    d_rvalid     = 1'b0;
    case (state)
      IDLE: begin
        if (!rst_b) begin
          if_gnt = pick_i;
          d_gnt  = pick_d;
          if (pick_i || pick_d) state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (!misaligned) begin
          mem_addr     = cur.addr;
          mem_rd_en    = !cur.we;
          mem_write_en = cur.we;
          mem_wdata    = cur.we ? cur.wdata : 32'h0;
        end
        state_nxt = (cur.we || misaligned || MEM_LAT == 1) ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt <= 4'd1) state_nxt = RESP;
      end
      RESP: begin
        if_rvalid = !cur.is_d;
        d_rvalid  = cur.is_d;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read data is shown live during RESP and held afterwards until the port's next response.
  assign if_rdata = if_rvalid ? rsp_data : if_rdata_q;
  assign d_rdata  = d_rvalid  ? rsp_data : d_rdata_q;
  assign if_err   = if_rvalid && misaligned;
  assign d_err    = d_rvalid && misaligned;

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state      <= IDLE;
      cur        <= '0;
      cnt        <= 4'd0;
      starve_cnt <= 3'd0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
    end else begin
      state <= state_nxt;
      if (if_gnt) begin
        cur <= '{addr: if_addr, wdata: 32'h0, we: 1'b0, is_d: 1'b0};
      end else if (d_gnt) begin
        cur <= '{addr: d_addr, wdata: d_wdata, we: d_we, is_d: 1'b1};
      end
      if (state == ISSUE)     cnt <= 4'(MEM_LAT - 1);
      else if (state == WAIT) cnt <= cnt - 4'd1;
      else                    cnt <= 4'd0;
      if (if_gnt)                                                starve_cnt <= 3'd0;
      else if (d_gnt && if_req && starve_cnt != 3'(STARVE_MAX)) starve_cnt <= starve_cnt + 3'd1;
      if (if_rvalid) if_rdata_q <= rsp_data;
      if (d_rvalid)  d_rdata_q  <= rsp_data;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, meaning cycles from read strobe to valid mem_rdata (legal 1..15).
REQ-002 SHALL have parameter STARVE_MAX, default 3, meaning maximum consecutive data grants while a fetch waits (legal 1..7).
REQ-003 SHALL have ports: clk in 1 clock; rst_b in 1, single clock domain, reset asynchronous and active-high (asserted = 1).
REQ-004 SHALL have fetch ports: if_req in 1 request; if_addr in 32 byte address; if_gnt out 1 accept; if_rvalid out 1 response; if_rdata out 32 read word; if_err out 1 misaligned.
REQ-005 SHALL have data ports: d_req in 1; d_we in 1 store=1/load=0; d_addr in 32; d_wdata in 32; d_gnt out 1; d_rvalid out 1; d_rdata out 32; d_err out 1.
REQ-006 SHALL have memory ports: mem_addr out 32; mem_wdata out 32, lane k = bits [8k+7:8k], byte 0 at lowest address; mem_write_en out 1; mem_rd_en out 1; mem_rdata in 32, same lane order.
REQ-007 SHALL have busy out 1, high whenever state is not IDLE.

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-009 SHALL assert if_gnt/d_gnt combinationally, only in IDLE, at most one per cycle, to a requester whose req is high.
REQ-010 SHALL capture the granted address, d_we, d_wdata and requester identity on the grant edge; IDLE->ISSUE.
REQ-011 SHALL arbitrate: data wins when both request, except fetch wins when starve_cnt == STARVE_MAX.
REQ-012 SHALL increment starve_cnt (saturating at STARVE_MAX) on a data grant with if_req high, clear it on any fetch grant, hold otherwise.
REQ-013 SHALL in ISSUE drive mem_addr from the captured address and pulse mem_rd_en (load/fetch) or mem_write_en with mem_wdata = captured d_wdata (store) for exactly one cycle.
REQ-014 SHALL go ISSUE->RESP for stores or MEM_LAT == 1; otherwise ISSUE->WAIT with countdown loaded to MEM_LAT-1.
REQ-015 SHALL leave WAIT for RESP when the countdown reaches 1, decrementing once per cycle.
REQ-016 SHALL in RESP pulse the owner's rvalid for one cycle with rdata = mem_rdata sampled that cycle (reads) or 0 (stores), then RESP->IDLE.
REQ-017 SHALL treat addr[1:0] != 0 as misaligned: grant normally, no mem strobe, ISSUE->RESP, rvalid with err=1 and rdata=0.
REQ-018 SHALL hold if_rdata/d_rdata stable until the next rvalid of that port; err valid only with rvalid.
REQ-019 SHALL drive mem_rd_en, mem_write_en, gnts, rvalids low in every cycle not named above.
REQ-020 SHALL give read latency gnt->rvalid of MEM_LAT+1 cycles, store ack of 2 cycles, and minimum spacing between grants of MEM_LAT+2 cycles.
REQ-021 SHALL ignore req deassertion or address change after grant; a req held through RESP is regranted in the following IDLE cycle.

Reset
REQ-022 SHALL, while rst_b = 1, force state IDLE, starve_cnt 0, countdown 0, all outputs 0 (mem_addr, mem_wdata, rdata included).
REQ-023 SHALL on reset mid-operation abort the access immediately (mem_write_en falls without waiting for clk) and emit no rvalid for it.
REQ-024 SHALL accept a grant in the first cycle after rst_b deasserts.

Verification
REQ-025 Fetch read, MEM_LAT=2: if_req, if_addr=0x100, mem_rdata=0xDEADBEEF at RESP -> if_gnt cycle 0, mem_rd_en cycle 1, if_rvalid with 0xDEADBEEF cycle 3.
REQ-026 Store: d_we=1, d_addr=0x20, d_wdata=0x11223344 -> mem_write_en cycle 1, mem_wdata[7:0]=0x44, d_rvalid cycle 2, d_rdata=0.
REQ-027 Starvation, STARVE_MAX=3: if_req and d_req held -> grant order D,D,D,I,D,D,D,I.
REQ-028 Misaligned: d_addr=0x13 load -> no mem strobe, d_rvalid cycle 2 with d_err=1, d_rdata=0.
REQ-029 Reset in WAIT: rst_b=1 mid-read -> outputs 0 asynchronously, no if_rvalid; next request after release completes normally.
REQ-030 MEM_LAT=1 and MEM_LAT=15 reads -> rvalid at gnt+2 and gnt+16 respectively.
